// File: rtl/noc_switch_alloc_pkg.sv
// Shared sizing, VC identifier type and port-decode helper for the switch allocator.
package noc_switch_alloc_pkg;

  localparam int VID_BITS  = 6;
  localparam int PORTS     = 5;
  localparam int CHANNELS  = 12;
  localparam int NUM_REQ   = PORTS * CHANNELS;
  localparam int PORT_BITS = $clog2(PORTS);
  localparam int CH_BITS   = $clog2(CHANNELS);

  typedef logic [VID_BITS-1:0]  vid_t;
  typedef logic [PORT_BITS-1:0] port_t;
  typedef logic [CH_BITS-1:0]   ch_t;

  function automatic port_t ovid_to_port(vid_t ovid);
    return port_t'(ovid / vid_t'(CHANNELS));
  endfunction

endpackage

// File: rtl/noc_switch_alloc_if.sv
// Request/grant bundle between the VC buffers and the switch allocator.
interface noc_switch_alloc_if;
  import noc_switch_alloc_pkg::*;

  // Handshake: an input VC raises req_valid with a stable req_ovid and holds both until it
  // sees its sa_gnt pulse; ovc_ready is a level "one flit fits" per output VC; each sa_gnt
  // pulse moves exactly one flit, and a still-high req_valid afterwards asks for the next one.
  logic [NUM_REQ-1:0] req_valid;
  vid_t [NUM_REQ-1:0] req_ovid;
  logic [NUM_REQ-1:0] ovc_ready;
  logic [NUM_REQ-1:0] sa_gnt;
  vid_t [NUM_REQ-1:0] g_ovid;
  logic               err_bad_ovid;

  modport master (
    output req_valid, req_ovid, ovc_ready,
    input  sa_gnt, g_ovid, err_bad_ovid
  );

  modport slave (
    input  req_valid, req_ovid, ovc_ready,
    output sa_gnt, g_ovid, err_bad_ovid
  );

endinterface

// File: rtl/noc_switch_alloc_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping at N.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          found
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_switch_alloc.sv
// Separable input-first switch allocator: per-input-port VC pick, then per-output-port port pick.
module noc_switch_alloc
  import noc_switch_alloc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  noc_switch_alloc_if.slave bus
);

  logic [NUM_REQ-1:0]  bad, elig, inflight;
  logic [NUM_REQ-1:0]  gnt_nxt, inflight_nxt, sa_gnt_q;
  vid_t [NUM_REQ-1:0]  g_ovid_nxt, g_ovid_q;
  logic                err_q;

  ch_t                 in_ptr   [PORTS];
  port_t               out_ptr  [PORTS];
  logic [CHANNELS-1:0] cand_oh  [PORTS];
  ch_t                 cand_idx [PORTS];
  vid_t                cand_vc  [PORTS];
  port_t               cand_op  [PORTS];
  logic [PORTS-1:0]    cand_any;
  logic [PORTS-1:0]    req2     [PORTS];
  logic [PORTS-1:0]    win_oh   [PORTS];
  port_t               win_idx  [PORTS];
  logic [PORTS-1:0]    win_any;
  logic [PORTS-1:0]    port_won;

  // inflight hides ovids granted last cycle, whose ovc_ready has not yet seen the flit.
  always_comb begin
    bad  = '0;
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bad[i]  = bus.req_valid[i] && (bus.req_ovid[i] >= vid_t'(NUM_REQ));
      elig[i] = bus.req_valid[i] && !bad[i] &&
                bus.ovc_ready[bus.req_ovid[i]] && !inflight[bus.req_ovid[i]];
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_in_arb
    rr_arb #(.N(CHANNELS)) u_in_arb (
      .req     (elig[p*CHANNELS +: CHANNELS]),
      .ptr     (in_ptr[p]),
      .gnt     (cand_oh[p]),
      .gnt_idx (cand_idx[p]),
      .found   (cand_any[p])
    );
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      cand_vc[p] = vid_t'(p * CHANNELS) + vid_t'(cand_idx[p]);
      cand_op[p] = ovid_to_port(bus.req_ovid[cand_vc[p]]);
    end
  end

  always_comb begin
    for (int q = 0; q < PORTS; q++) begin
      req2[q] = '0;
      for (int p = 0; p < PORTS; p++)
        req2[q][p] = cand_any[p] && (cand_op[p] == port_t'(q));
    end
  end

  for (genvar q = 0; q < PORTS; q++) begin : g_out_arb
    rr_arb #(.N(PORTS)) u_out_arb (
      .req     (req2[q]),
      .ptr     (out_ptr[q]),
      .gnt     (win_oh[q]),
      .gnt_idx (win_idx[q]),
      .found   (win_any[q])
    );
  end

  always_comb begin
    port_won     = '0;
    gnt_nxt      = '0;
    g_ovid_nxt   = '0;
    inflight_nxt = '0;
    for (int q = 0; q < PORTS; q++)
      port_won = port_won | win_oh[q];
    for (int p = 0; p < PORTS; p++)
      if (port_won[p]) gnt_nxt[p*CHANNELS +: CHANNELS] = cand_oh[p];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_nxt[i]) begin
        g_ovid_nxt[i]                 = bus.req_ovid[i];
        inflight_nxt[bus.req_ovid[i]] = 1'b1;
      end
    end
  end

  // Stage-1 losers keep their in_ptr so the same VC is retried first next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_gnt_q <= '0;
      g_ovid_q <= '0;
      inflight <= '0;
      err_q    <= 1'b0;
      for (int p = 0; p < PORTS; p++) begin
        in_ptr[p]  <= '0;
        out_ptr[p] <= '0;
      end
    end else begin
      sa_gnt_q <= gnt_nxt;
      g_ovid_q <= g_ovid_nxt;
      inflight <= inflight_nxt;
      if (|bad) err_q <= 1'b1;
      for (int p = 0; p < PORTS; p++)
        if (port_won[p])
          in_ptr[p] <= (cand_idx[p] == ch_t'(CHANNELS-1)) ? '0 : cand_idx[p] + 1'b1;
      for (int q = 0; q < PORTS; q++)
        if (win_any[q])
          out_ptr[q] <= (win_idx[q] == port_t'(PORTS-1)) ? '0 : win_idx[q] + 1'b1;
    end
  end

  assign bus.sa_gnt       = sa_gnt_q;
  assign bus.g_ovid       = g_ovid_q;
  assign bus.err_bad_ovid = err_q;

endmodule

// File: tb/tb_noc_switch_alloc.sv
// Directed bench for noc_switch_alloc: grant latency, rotation, conflicts, backpressure, errors, reset.
module tb_noc_switch_alloc;
  import noc_switch_alloc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_switch_alloc_if bus ();

  noc_switch_alloc u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [NUM_REQ-1:0] ready_q;

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Structural invariants of whatever grant set is currently registered.
  task automatic check_inv(input string tag);
    logic ok;
    int   cnt;
    ok = 1'b1;
    for (int p = 0; p < PORTS; p++)
      if ($countones(bus.sa_gnt[p*CHANNELS +: CHANNELS]) > 1) ok = 1'b0;
    for (int q = 0; q < PORTS; q++) begin
      cnt = 0;
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.sa_gnt[i] && (int'(bus.g_ovid[i]) / CHANNELS == q)) cnt++;
      if (cnt > 1) ok = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (bus.sa_gnt[i] && ((int'(bus.g_ovid[i]) >= NUM_REQ) || !ready_q[bus.g_ovid[i]]))
        ok = 1'b0;
    chk({tag, "_inv"}, 384'(ok), 384'(1'b1));
  endtask

  task automatic step(input string tag);
    ready_q = bus.ovc_ready;
    @(posedge clk);
    #1;
    check_inv(tag);
  endtask

  task automatic expect_gnt(input string tag, input int vc, input int ov);
    logic [NUM_REQ-1:0] e_g;
    vid_t [NUM_REQ-1:0] e_o;
    e_g = '0;
    e_o = '0;
    if (vc >= 0) begin
      e_g[vc] = 1'b1;
      e_o[vc] = vid_t'(ov);
    end
    chk({tag, "_gnt"},  384'(bus.sa_gnt), 384'(e_g));
    chk({tag, "_ovid"}, 384'(bus.g_ovid), 384'(e_o));
  endtask

  task automatic set_req(input int vc, input int ov);
    bus.req_valid[vc] = 1'b1;
    bus.req_ovid[vc]  = vid_t'(ov);
  endtask

  task automatic clr_req(input int vc);
    bus.req_valid[vc] = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_ovid  = '0;
    bus.ovc_ready = '1;
    ready_q       = '1;
    #1;
    expect_gnt("init_rst", -1, 0);
    chk("init_err", 384'(bus.err_bad_ovid), 384'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // single request, one-cycle latency
    set_req(13, 27);
    step("single");      expect_gnt("single", 13, 27);
    clr_req(13);
    step("single_idle"); expect_gnt("single_idle", -1, 0);

    // three VCs of port 0 rotate through the input arbiter
    set_req(0, 12); set_req(1, 24); set_req(2, 36);
    step("rot0"); expect_gnt("rot0", 0, 12);
    step("rot1"); expect_gnt("rot1", 1, 24);
    step("rot2"); expect_gnt("rot2", 2, 36);
    step("rot3"); expect_gnt("rot3", 0, 12);
    clr_req(0); clr_req(1); clr_req(2);
    step("rot_idle"); expect_gnt("rot_idle", -1, 0);

    // in_ptr[0] is 1; VC11 wins, pointer wraps to 0, so VC1 beats VC10
    set_req(11, 12);
    step("chwrap_a"); expect_gnt("chwrap_a", 11, 12);
    clr_req(11); set_req(10, 14); set_req(1, 13);
    step("chwrap_b"); expect_gnt("chwrap_b", 1, 13);
    clr_req(1);
    step("chwrap_c"); expect_gnt("chwrap_c", 10, 14);
    clr_req(10);
    step("chwrap_idle"); expect_gnt("chwrap_idle", -1, 0);

    // backpressure on ovid 40 for four cycles
    set_req(5, 40);
    bus.ovc_ready[40] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step("bp_hold"); expect_gnt("bp_hold", -1, 0);
    end
    bus.ovc_ready[40] = 1'b1;
    step("bp_go"); expect_gnt("bp_go", 5, 40);
    clr_req(5);
    step("bp_idle"); expect_gnt("bp_idle", -1, 0);

    // out-of-range ovid: never granted, sticky error
    chk("bad_err_before", 384'(bus.err_bad_ovid), 384'(1'b0));
    set_req(3, 63);
    step("bad_a"); expect_gnt("bad_a", -1, 0);
    chk("bad_err_a", 384'(bus.err_bad_ovid), 384'(1'b1));
    step("bad_b"); expect_gnt("bad_b", -1, 0);
    chk("bad_err_b", 384'(bus.err_bad_ovid), 384'(1'b1));
    clr_req(3);
    step("bad_c"); expect_gnt("bad_c", -1, 0);
    chk("bad_err_sticky", 384'(bus.err_bad_ovid), 384'(1'b1));

    // traffic then asynchronous reset; out_ptr[2] is 1 here so port 1 wins
    set_req(0, 24); set_req(12, 24);
    step("pre_rst"); expect_gnt("pre_rst", 12, 24);
    #2;
    rst = 1'b1;
    #1;
    expect_gnt("rst_async", -1, 0);
    chk("rst_err", 384'(bus.err_bad_ovid), 384'(1'b0));
    @(posedge clk);
    #1;
    expect_gnt("rst_hold", -1, 0);
    rst = 1'b0;

    // output conflict on ovid 24 from fresh pointers; inflight forces idle gaps
    step("oc0"); expect_gnt("oc0", 0, 24);
    step("oc1"); expect_gnt("oc1", -1, 0);
    step("oc2"); expect_gnt("oc2", 12, 24);
    step("oc3"); expect_gnt("oc3", -1, 0);
    step("oc4"); expect_gnt("oc4", 0, 24);
    clr_req(0); clr_req(12);
    step("oc_idle"); expect_gnt("oc_idle", -1, 0);

    // port 4 wins output 0 so out_ptr[0] wraps to 0; then port 1 has priority
    set_req(48, 0);
    step("pwrap_a"); expect_gnt("pwrap_a", 48, 0);
    clr_req(48);
    step("pwrap_idle"); expect_gnt("pwrap_idle", -1, 0);
    set_req(48, 1); set_req(12, 1);
    step("pwrap_b"); expect_gnt("pwrap_b", 12, 1);
    step("pwrap_c"); expect_gnt("pwrap_c", -1, 0);
    step("pwrap_d"); expect_gnt("pwrap_d", 48, 1);
    clr_req(48); clr_req(12);
    step("end_idle"); expect_gnt("end_idle", -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
